// File: rtl/duck_game_fsm_if.sv
// Game-flow bus between the game controller and its surroundings (duck block, gun, HUD).
// The controller drives the master side; the gun, duck block and HUD see the slave side.
interface duck_game_fsm_if;
  logic        start;
  logic        trigger;
  logic        aim_hit;
  logic        flew_away;
  logic        duck_ded_done;
  logic [2:0]  state;
  logic        new_round;
  logic [1:0]  shots_left;
  logic [3:0]  ducks_hit;
  logic [3:0]  duck_num;
  logic [3:0]  round;
  logic [15:0] score;
  logic        game_over;

  modport master (
    input  start, trigger, aim_hit, flew_away, duck_ded_done,
    output state, new_round, shots_left, ducks_hit, duck_num, round, score, game_over
  );

  modport slave (
    output start, trigger, aim_hit, flew_away, duck_ded_done,
    input  state, new_round, shots_left, ducks_hit, duck_num, round, score, game_over
  );
endinterface

// File: rtl/duck_game_fsm.sv
// Game-flow controller for the duck hunt: sequences title, per-duck flight, shooting and
// round progression, and keeps the shot/hit/duck/round/score counters for the HUD.
module duck_game_fsm #(
  parameter int DUCKS_PER_ROUND = 10,
  parameter int HITS_TO_PASS    = 6,
  parameter int SHOTS_PER_DUCK  = 3,
  parameter int INIT_FRAMES     = 60,
  parameter int FLEW_FRAMES     = 90,
  parameter int FLY_TIMEOUT     = 600,
  parameter int POINTS          = 500
) (
  input logic             Clk,
  input logic             Reset_n,
  input logic             frame_clk,
  duck_game_fsm_if.master bus
);
  typedef enum logic [2:0] {
    TITLE     = 3'b000,
    INIT      = 3'b001,
    FLY       = 3'b010,
    FLEW      = 3'b011,
    SHOT      = 3'b100,
    NEXT      = 3'b101,
    GAME_OVER = 3'b110
  } state_t;

  localparam int MAX_FRAMES = (FLY_TIMEOUT > INIT_FRAMES)
                            ? ((FLY_TIMEOUT > FLEW_FRAMES) ? FLY_TIMEOUT : FLEW_FRAMES)
                            : ((INIT_FRAMES > FLEW_FRAMES) ? INIT_FRAMES : FLEW_FRAMES);
  localparam int TIMER_W = $clog2(MAX_FRAMES + 1);
  localparam logic [TIMER_W-1:0] INIT_LAST = TIMER_W'(INIT_FRAMES - 1);
  localparam logic [TIMER_W-1:0] FLEW_LAST = TIMER_W'(FLEW_FRAMES - 1);
  localparam logic [TIMER_W-1:0] FLY_LAST  = TIMER_W'(FLY_TIMEOUT - 1);

  state_t              state_reg, state_next;
  logic [TIMER_W-1:0]  timer_reg, timer_next;
  logic [1:0]          shots_reg, shots_next;
  logic [3:0]          hits_reg, hits_next;
  logic [3:0]          duck_reg, duck_next;
  logic [3:0]          round_reg, round_next;
  logic [15:0]         score_reg, score_next;
  logic                new_round_reg, game_over_reg;
  logic [1:0]          frame_sync_reg;
  logic                frame_edge;
  logic [16:0]         score_sum;
  logic [3:0]          duck_inc;
  logic                shot_fired, hit_now, miss_last, fly_timeout;

  // frame_clk is slow and unrelated to Clk; two flops resynchronise it and give the edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) frame_sync_reg <= 2'b00;
    else          frame_sync_reg <= {frame_sync_reg[0], frame_clk};
  end
  assign frame_edge = frame_sync_reg[0] & ~frame_sync_reg[1];

  assign score_sum   = {1'b0, score_reg} + 17'(POINTS);
  assign duck_inc    = duck_reg + 4'd1;
  assign shot_fired  = bus.trigger && (shots_reg != 2'd0);
  assign hit_now     = shot_fired && bus.aim_hit;
  assign miss_last   = shot_fired && !bus.aim_hit && (shots_reg == 2'd1);
  assign fly_timeout = frame_edge && (timer_reg == FLY_LAST);

  always_comb begin
    state_next = state_reg;
    shots_next = shots_reg;
    hits_next  = hits_reg;
    duck_next  = duck_reg;
    round_next = round_reg;
    score_next = score_reg;
    timer_next = timer_reg;
    unique case (state_reg)
      TITLE, GAME_OVER: if (bus.start) begin
        state_next = INIT;
        score_next = 16'd0;
        round_next = 4'd1;
        duck_next  = 4'd0;
        hits_next  = 4'd0;
      end
      INIT: if (frame_edge && timer_reg == INIT_LAST) state_next = FLY;
      FLY: begin
        if (shot_fired) shots_next = shots_reg - 2'd1;
        // A hit outranks a simultaneous fly-away or timeout.
        if (hit_now) begin
          state_next = SHOT;
          hits_next  = hits_reg + 4'd1;
          score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end else if (miss_last || bus.flew_away || fly_timeout) begin
          state_next = FLEW;
        end
      end
      SHOT: if (bus.duck_ded_done) state_next = NEXT;
      FLEW: if (frame_edge && timer_reg == FLEW_LAST) state_next = NEXT;
      NEXT: begin
        if (duck_inc < 4'(DUCKS_PER_ROUND)) begin
          state_next = INIT;
          duck_next  = duck_inc;
        end else if (hits_reg >= 4'(HITS_TO_PASS)) begin
          state_next = INIT;
          duck_next  = 4'd0;
          hits_next  = 4'd0;
          round_next = (round_reg == 4'd15) ? 4'd15 : round_reg + 4'd1;
        end else begin
          state_next = GAME_OVER;
          duck_next  = duck_inc;
        end
      end
      default: state_next = TITLE;
    endcase
    // Every fresh duck starts with a full magazine.
    if (state_next == INIT && state_reg != INIT) shots_next = 2'(SHOTS_PER_DUCK);
    if (state_next != state_reg) timer_next = '0;
    else if (frame_edge)         timer_next = timer_reg + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg     <= TITLE;
      timer_reg     <= '0;
      shots_reg     <= 2'd0;
      hits_reg      <= 4'd0;
      duck_reg      <= 4'd0;
      round_reg     <= 4'd1;
      score_reg     <= 16'd0;
      new_round_reg <= 1'b0;
      game_over_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      shots_reg     <= shots_next;
      hits_reg      <= hits_next;
      duck_reg      <= duck_next;
      round_reg     <= round_next;
      score_reg     <= score_next;
      new_round_reg <= (state_next == INIT);
      game_over_reg <= (state_next == GAME_OVER);
    end
  end

  assign bus.state      = state_reg;
  assign bus.new_round  = new_round_reg;
  assign bus.shots_left = shots_reg;
  assign bus.ducks_hit  = hits_reg;
  assign bus.duck_num   = duck_reg;
  assign bus.round      = round_reg;
  assign bus.score      = score_reg;
  assign bus.game_over  = game_over_reg;
endmodule

// File: tb/tb_duck_game_fsm.sv
// Scoreboard bench for duck_game_fsm: stimulus tasks queue each predicted output snapshot,
// and a monitor pops and compares one whenever the DUT's output bundle changes.
module tb_duck_game_fsm;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic frame_clk = 1'b0;

  duck_game_fsm_if bus ();

  duck_game_fsm dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  always #5  Clk = ~Clk;
  always #20 frame_clk = ~frame_clk;   // one frame every 4 Clk cycles

  typedef struct packed {
    logic [2:0]  state;
    logic        new_round;
    logic [1:0]  shots;
    logic [3:0]  hits;
    logic [3:0]  duck;
    logic [3:0]  round;
    logic [15:0] score;
    logic        game_over;
  } obs_t;

  obs_t q[$];
  obs_t m;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_en  = 1'b0;

  function automatic obs_t sample();
    obs_t o;
    o.state     = bus.state;
    o.new_round = bus.new_round;
    o.shots     = bus.shots_left;
    o.hits      = bus.ducks_hit;
    o.duck      = bus.duck_num;
    o.round     = bus.round;
    o.score     = bus.score;
    o.game_over = bus.game_over;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("st=%0d nr=%b sh=%0d hit=%0d dk=%0d rd=%0d sc=%h go=%b",
                     o.state, o.new_round, o.shots, o.hits, o.duck, o.round, o.score,
                     o.game_over);
  endfunction

  // Monitor: every change of the output bundle is one transaction to check.
  initial begin
    obs_t prev, cur, e;
    prev = '1;
    wait (mon_en);
    forever begin
      @(negedge Clk);
      cur = sample();
      if (cur !== prev) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change got %s required no change", fmt(cur));
        end else begin
          e = q.pop_front();
          if (cur !== e) begin
            n_fail++;
            $display("FAIL txn%0d got %s required %s", n_tests, fmt(cur), fmt(e));
          end else begin
            $display("[MON] txn%0d ok %s", n_tests, fmt(cur));
          end
        end
        prev = cur;
      end
    end
  end

  task automatic push();
    q.push_back(m);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (bus.state == s) break;
    end
    if (i == budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout got state=%0d required state=%0d", tag, bus.state, s);
    end
  endtask

  task automatic pulse(input logic st, input logic tr, input logic aim, input logic fa,
                       input logic ded);
    @(posedge Clk); #1;
    bus.start = st; bus.trigger = tr; bus.aim_hit = aim;
    bus.flew_away = fa; bus.duck_ded_done = ded;
    @(posedge Clk); #1;
    bus.start = 1'b0; bus.trigger = 1'b0; bus.aim_hit = 1'b0;
    bus.flew_away = 1'b0; bus.duck_ded_done = 1'b0;
  endtask

  task automatic set_reset_model();
    m.state = 3'd0; m.new_round = 1'b0; m.shots = 2'd0; m.hits = 4'd0;
    m.duck = 4'd0; m.round = 4'd1; m.score = 16'd0; m.game_over = 1'b0;
  endtask

  task automatic do_start();
    m.state = 3'd1; m.new_round = 1'b1; m.shots = 2'd3; m.hits = 4'd0;
    m.duck = 4'd0; m.round = 4'd1; m.score = 16'd0; m.game_over = 1'b0;
    push();
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_state(3'd1, 5, "start");
  endtask

  task automatic to_fly();
    m.state = 3'd2; m.new_round = 1'b0;
    push();
    wait_state(3'd2, 300, "init_to_fly");
  endtask

  // Hand-computed consequences of leaving NEXT.
  task automatic next_exit();
    m.duck = m.duck + 4'd1;
    if (m.duck < 4'd10) begin
      m.state = 3'd1; m.shots = 2'd3; m.new_round = 1'b1;
    end else if (m.hits >= 4'd6) begin
      m.round = (m.round == 4'd15) ? 4'd15 : m.round + 4'd1;
      m.duck = 4'd0; m.hits = 4'd0;
      m.state = 3'd1; m.shots = 2'd3; m.new_round = 1'b1;
    end else begin
      m.state = 3'd6; m.game_over = 1'b1;
    end
    push();
  endtask

  task automatic do_hit(input logic fa);
    m.state = 3'd4; m.shots = m.shots - 2'd1; m.hits = m.hits + 4'd1;
    m.score = (int'(m.score) > 65535 - 500) ? 16'hFFFF : m.score + 16'd500;
    push();
    pulse(1'b0, 1'b1, 1'b1, fa, 1'b0);
    wait_state(3'd4, 5, "hit");
  endtask

  task automatic do_ded();
    m.state = 3'd5;
    push();
    next_exit();
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_state(m.state, 5, "ded_done");
  endtask

  task automatic do_miss();
    if (m.state == 3'd2 && m.shots != 2'd0) begin
      m.shots = m.shots - 2'd1;
      if (m.shots == 2'd0) m.state = 3'd3;
      push();
    end
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic flew_out();
    m.state = 3'd5;
    push();
    next_exit();
    wait_state(m.state, 400, "flew_to_next");
  endtask

  task automatic play_duck(input int kind);
    to_fly();
    if (kind == 0) begin
      do_hit(1'b0);
      do_ded();
    end else if (kind == 1) begin
      m.state = 3'd3;
      push();
      pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      wait_state(3'd3, 5, "flew_away");
      flew_out();
    end else begin
      m.state = 3'd3;
      push();
      wait_state(3'd3, 2500, "fly_timeout");
      flew_out();
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.trigger = 1'b0; bus.aim_hit = 1'b0;
    bus.flew_away = 1'b0; bus.duck_ded_done = 1'b0;
    set_reset_model();
    push();
    mon_en = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;

    // Hit on the first shot, fall, next duck.
    do_start();
    to_fly();
    do_hit(1'b0);
    do_ded();

    // Three misses empty the gun; a fourth trigger is ignored.
    to_fly();
    repeat (4) do_miss();
    flew_out();

    // Hit and fly-away in the same cycle: the hit wins.
    to_fly();
    do_hit(1'b1);
    do_ded();

    play_duck(1);

    // Asynchronous reset while the duck is flying.
    to_fly();
    set_reset_model();
    push();
    @(posedge Clk); #2 Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Full game: pass round 1 with exactly 6 hits, clear rounds 2..14, score saturates.
    do_start();
    for (int d = 0; d < 10; d++) play_duck((d < 6) ? 0 : 1);
    for (int r = 0; r < 13; r++)
      for (int d = 0; d < 10; d++) play_duck(0);
    // Round 15: 5 hits, one timeout, then fly-aways -> game over.
    for (int d = 0; d < 10; d++) play_duck((d < 5) ? 0 : ((d == 5) ? 2 : 1));

    // Restart from game over clears everything.
    do_start();
    repeat (5) @(negedge Clk);

    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations got %0d required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
